// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator control sequencer.
//   state_e     : sequencer states
//   op_class_e  : opcode class produced by the decoder
//   OP_*        : opcode values
//   ALU_*       : AluOp codes driven to the datapath ALU
//   MEMDST_*    : MemDst codes (memory address source)
package acc_ctrl_pkg;

    typedef enum logic [3:0] {
        StRstWait,
        StFetch,
        StDecode,
        StLda,
        StLdb,
        StExec,
        StWb,
        StSt,
        StHalt,
        StTrap
    } state_e;

    typedef enum logic [1:0] {
        ClsArith,
        ClsNop,
        ClsHalt,
        ClsIllegal
    } op_class_e;

    localparam int unsigned OP_NOP  = 'h0;
    localparam int unsigned OP_AADD = 'h1;
    localparam int unsigned OP_ASUB = 'h2;
    localparam int unsigned OP_AAND = 'h3;
    localparam int unsigned OP_AOR  = 'h4;
    localparam int unsigned OP_HALT = 'hF;

    localparam int unsigned ALU_AND = 0;
    localparam int unsigned ALU_OR  = 1;
    localparam int unsigned ALU_ADD = 2;
    localparam int unsigned ALU_SUB = 3;

    localparam int unsigned MEMDST_PC      = 0;
    localparam int unsigned MEMDST_SHELLEY = 3;

endpackage

// File: rtl/acc_ctrl_decode.sv
// Combinational opcode decoder for the accumulator sequencer.
// Ports:
//   opcode   in   opcode field
//   alu_op   out  ALU operation for arithmetic opcodes, 0 otherwise
//   op_class out  arith / nop / halt / illegal
module acc_ctrl_decode
    import acc_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W   = 4,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic [OPC_W-1:0]   opcode,
    output logic [ALUOP_W-1:0] alu_op,
    output op_class_e          op_class
);

    always_comb begin
        alu_op   = '0;
        op_class = ClsIllegal;
        case (opcode)
            OPC_W'(OP_NOP):  op_class = ClsNop;
            OPC_W'(OP_AADD): begin
                op_class = ClsArith;
                alu_op   = ALUOP_W'(ALU_ADD);
            end
            OPC_W'(OP_ASUB): begin
                op_class = ClsArith;
                alu_op   = ALUOP_W'(ALU_SUB);
            end
            OPC_W'(OP_AAND): begin
                op_class = ClsArith;
                alu_op   = ALUOP_W'(ALU_AND);
            end
            OPC_W'(OP_AOR): begin
                op_class = ClsArith;
                alu_op   = ALUOP_W'(ALU_OR);
            end
            OPC_W'(OP_HALT): op_class = ClsHalt;
            default: ;
        endcase
    end

endmodule

// File: rtl/accumulator_control_fsm.sv
// Multi-cycle control sequencer for the mary/shelley accumulator datapath.
// Sequence per arithmetic instruction: FETCH, DECODE, LDA, LDB, EXEC, WB, ST.
// Memory states wait on mem_ready; control outputs are Mealy (state + mem_ready).
// Optional feature macro: ACC_OVF_TRAP_EN -- ALU overflow on AADD/ASUB in EXEC
// diverts to a one-cycle TRAP that loads the trap vector instead of writing back.
// Ports:
//   clock, reset (async, active low), instruction, overflow_output, mem_ready
//   datapath controls: MemWrite, MemSrc, MemDst, PCSrc, SPSrc, PCWrite, SPWrite,
//     InstWrite, mary_write, shelley_write, comp_write, ra_write, mary_src,
//     shelley_src, ra_src, SrcA, SrcB, AluOp
//   status: halted, illegal (DECODE pulse), retired (completed instruction count)
module accumulator_control_fsm
    import acc_ctrl_pkg::*;
#(
    parameter int unsigned INST_W     = 16,
    parameter int unsigned OPC_W      = 4,
    parameter int unsigned OPC_LSB    = 12,
    parameter int unsigned ALUOP_W    = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TRAP_PCSRC = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INST_W-1:0]  instruction,
    input  logic               overflow_output,
    input  logic               mem_ready,
    output logic               MemWrite,
    output logic [1:0]         MemSrc,
    output logic [2:0]         MemDst,
    output logic [2:0]         PCSrc,
    output logic [2:0]         SPSrc,
    output logic               PCWrite,
    output logic               SPWrite,
    output logic               InstWrite,
    output logic               mary_write,
    output logic               shelley_write,
    output logic               comp_write,
    output logic               ra_write,
    output logic [1:0]         mary_src,
    output logic [1:0]         shelley_src,
    output logic               ra_src,
    output logic               SrcA,
    output logic [1:0]         SrcB,
    output logic [ALUOP_W-1:0] AluOp,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    state_e             state_q;
    logic [OPC_W-1:0]   opc_q;
    logic [CNT_W-1:0]   retired_q;

    logic [OPC_W-1:0]   opc_in;
    logic [OPC_W-1:0]   dec_opc;
    logic [ALUOP_W-1:0] dec_alu;
    op_class_e          dec_class;
    logic               trap_take;

    logic unused_inst;
    assign unused_inst = ^instruction;

    assign opc_in = instruction[OPC_LSB +: OPC_W];

    // DECODE classifies the live instruction; later states use the latched opcode.
    assign dec_opc = (state_q == StDecode) ? opc_in : opc_q;

    acc_ctrl_decode #(
        .OPC_W   (OPC_W),
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .opcode   (dec_opc),
        .alu_op   (dec_alu),
        .op_class (dec_class)
    );

`ifdef ACC_OVF_TRAP_EN
    assign trap_take = overflow_output &&
                       ((opc_q == OPC_W'(OP_AADD)) || (opc_q == OPC_W'(OP_ASUB)));
`else
    logic unused_ovf;
    assign unused_ovf = overflow_output;
    assign trap_take  = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StRstWait;
            opc_q     <= '0;
            retired_q <= '0;
        end else begin
            case (state_q)
                StRstWait: state_q <= StFetch;
                StFetch: begin
                    if (mem_ready) state_q <= StDecode;
                end
                StDecode: begin
                    opc_q <= opc_in;
                    case (dec_class)
                        ClsArith: state_q <= StLda;
                        ClsHalt:  state_q <= StHalt;
                        default: begin
                            // NOP and illegal opcodes both count as completed.
                            retired_q <= retired_q + CNT_W'(1);
                            state_q   <= StFetch;
                        end
                    endcase
                end
                StLda: begin
                    if (mem_ready) state_q <= StLdb;
                end
                StLdb: begin
                    if (mem_ready) state_q <= StExec;
                end
                StExec: state_q <= trap_take ? StTrap : StWb;
                StWb:   state_q <= StSt;
                StSt: begin
                    if (mem_ready) begin
                        retired_q <= retired_q + CNT_W'(1);
                        state_q   <= StFetch;
                    end
                end
                StHalt: state_q <= StHalt;
                StTrap: state_q <= StFetch;
                default: state_q <= StRstWait;
            endcase
        end
    end

    // Register-write strobes are qualified by mem_ready so each access
    // produces a single pulse however long memory stalls.
    always_comb begin
        MemWrite      = 1'b0;
        MemSrc        = '0;
        MemDst        = '0;
        PCSrc         = '0;
        SPSrc         = '0;
        PCWrite       = 1'b0;
        SPWrite       = 1'b0;
        InstWrite     = 1'b0;
        mary_write    = 1'b0;
        shelley_write = 1'b0;
        comp_write    = 1'b0;
        ra_write      = 1'b0;
        mary_src      = '0;
        shelley_src   = '0;
        ra_src        = 1'b0;
        SrcA          = 1'b0;
        SrcB          = '0;
        AluOp         = '0;
        halted        = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            StFetch: begin
                MemDst    = 3'(MEMDST_PC);
                InstWrite = mem_ready;
                PCWrite   = mem_ready;
            end
            StDecode: illegal = (dec_class == ClsIllegal);
            StLda: begin
                MemDst     = 3'(MEMDST_PC);
                mary_write = mem_ready;
                PCWrite    = mem_ready;
            end
            StLdb: begin
                MemDst        = 3'(MEMDST_PC);
                shelley_write = mem_ready;
                PCWrite       = mem_ready;
            end
            StExec: begin
                AluOp      = dec_alu;
                comp_write = 1'b1;
            end
            StWb: begin
                mary_src   = 2'd1;
                mary_write = 1'b1;
                AluOp      = dec_alu;
            end
            StSt: begin
                MemDst   = 3'(MEMDST_SHELLEY);
                MemWrite = 1'b1;
            end
            StHalt: halted = 1'b1;
            StTrap: begin
                PCSrc   = 3'(TRAP_PCSRC);
                PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign retired = retired_q;

endmodule
